mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 64-bit pipelined RISC-V core.
- Captures memory-stage results, sign/zero-extends load data by funct3 and address offset, and selects the writeback source.
- Drives the register file write port (RegWrite, write_reg, write_data) directly; the register file sits immediately downstream.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- NREG_BITS, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  synchronous active-low reset.
- stall_i  in  1  hold the stage register contents.
- flush_i  in  1  load a bubble (valid=0).
- mem_valid_i  in  1  the MEM-stage instruction is valid.
- mem_reg_write_i  in  1  the instruction writes rd.
- mem_wb_sel_i  in  2  writeback source: 00 ALU, 01 load, 10 PC+4 (link), 11 ALU.
- mem_rd_i  in  5  destination register.
- mem_funct3_i  in  3  load width/sign.
- mem_addr_lo_i  in  3  effective address bits [2:0].
- mem_alu_result_i  in  64  ALU result.
- mem_load_data_i  in  64  doubleword read from data memory (8-byte aligned).
- mem_pc4_i  in  64  PC+4 of the instruction.
- RegWrite  out  1  register file write enable.
- write_reg  out  5  register file write index.
- write_data  out  64  register file write data.
- wb_valid_o  out  1  the WB slot holds a valid instruction.

Behaviour:
- Reset nrst, synchronous, active-low; clock clk. While nrst=0 at a posedge, all stage registers clear to 0. After reset: RegWrite=0, write_reg=0, write_data=0, wb_valid_o=0.
- Update priority at each posedge: reset > flush_i > stall_i > load.
  - flush_i=1: valid<=0 and reg_write<=0; other fields are don't-care, but they are cleared to 0.
  - stall_i=1 with flush_i=0: all fields hold.
  - Otherwise: all mem_* inputs are captured.
- Latency: an instruction present on the mem_* inputs at posedge N appears on the outputs after N. The register file writes it at posedge N+1.
- Outputs are combinational from the stage register only; no input-to-output combinational path.
- RegWrite = valid & reg_write & (rd != 0). write_reg = rd always, including rd=0. wb_valid_o = valid.
- write_data mux: sel 00/11 gives the ALU result, 01 gives the extracted load, 10 gives pc4.
- Load extraction with off = addr_lo:
  - funct3 000 lb: byte at bits [8*off+7 : 8*off], sign-extended.
  - 100 lbu: same byte, zero-extended.
  - 001 lh / 101 lhu: halfword at index off[2:1]; off[0] is ignored.
  - 010 lw / 110 lwu: word at index off[2]; off[1:0] are ignored.
  - 011 ld and 111: the full 64 bits.
- Misaligned offsets are truncated as above; no exception is raised in this stage.
- Bubble (valid=0): write_data still reflects the mux output, RegWrite=0.
- Reset during a stall or flush: reset wins; all outputs are 0 on the next cycle.
- Stall held for many cycles: outputs stay constant, and RegWrite remains asserted if it was asserted. Rewriting the same value is idempotent, and the register file tolerates it.

Optional Feature:
- Macro WB_INSTRET_EN.
- When defined:
  - Adds output instret_o (64) holding a retired-instruction counter.
  - The counter increments by 1 on each posedge where valid=1 and the stage is not stalled, i.e. the instruction leaves WB.
  - It clears on reset and wraps from 2^64-1 to 0.
  - A flush does not decrement it.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then ALU write: drive nrst=0 for 2 cycles, then valid=1, reg_write=1, sel=00, rd=5, alu=0x1234. After the next posedge: RegWrite=1, write_reg=5, write_data=0x1234, wb_valid_o=1.
- Load extraction: load_data=0x8877_6655_4433_2211 with sel=01:
  - lb off=7: 0xFFFF_FFFF_FFFF_FF88.
  - lbu off=7: 0x88.
  - lh off=6: 0xFFFF_FFFF_FFFF_8877.
  - lhu off=2: 0x4433.
  - lw off=4: 0xFFFF_FFFF_8877_6655.
  - lwu off=0: 0x4433_2211.
  - ld: 0x8877_6655_4433_2211.
- x0 suppression: rd=0, reg_write=1, alu=0xDEAD gives RegWrite=0, write_reg=0, write_data=0xDEAD.
- Link writeback: sel=10, pc4=0x1000_0004, rd=1 gives write_data=0x1000_0004, RegWrite=1.
- Stall/flush priority:
  - Capture rd=7, then assert stall with new inputs rd=9 for 3 cycles: outputs hold rd=7.
  - Assert stall and flush together: next cycle wb_valid_o=0, RegWrite=0.
  - Assert nrst=0 during the stall: all outputs are 0.
- WB_INSTRET_EN: 4 valid instructions, 1 flushed bubble, and 2 stall cycles give instret_o=4. Preloading via forced state to 0xFFFF_FFFF_FFFF_FFFF and retiring one instruction gives 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB stage register, load extraction and writeback select; WB_INSTRET_EN adds the instret_o retire counter
module mem_wb_stage #(
  parameter int XLEN = 64,
  parameter int NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 mem_valid_i,
  input  logic                 mem_reg_write_i,
  input  logic [1:0]           mem_wb_sel_i,
  input  logic [NREG_BITS-1:0] mem_rd_i,
  input  logic [2:0]           mem_funct3_i,
  input  logic [2:0]           mem_addr_lo_i,
  input  logic [XLEN-1:0]      mem_alu_result_i,
  input  logic [XLEN-1:0]      mem_load_data_i,
  input  logic [XLEN-1:0]      mem_pc4_i,
  output logic                 RegWrite,
  output logic [NREG_BITS-1:0] write_reg,
  output logic [XLEN-1:0]      write_data,
  output logic                 wb_valid_o
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]          instret_o
`endif
);
  logic                 valid_q, reg_write_q;
  logic [1:0]           sel_q;
  logic [NREG_BITS-1:0] rd_q;
  logic [2:0]           funct3_q, addr_q;
  logic [XLEN-1:0]      alu_q, load_q, pc4_q, load_ext;
  logic [7:0]           b;
  logic [15:0]          h;
  logic [31:0]          w;
  always_ff @(posedge clk) begin
    if (!nrst || flush_i) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      sel_q       <= '0;
      rd_q        <= '0;
      funct3_q    <= '0;
      addr_q      <= '0;
      alu_q       <= '0;
      load_q      <= '0;
      pc4_q       <= '0;
    end else if (!stall_i) begin
      valid_q     <= mem_valid_i;
      reg_write_q <= mem_reg_write_i;
      sel_q       <= mem_wb_sel_i;
      rd_q        <= mem_rd_i;
      funct3_q    <= mem_funct3_i;
      addr_q      <= mem_addr_lo_i;
      alu_q       <= mem_alu_result_i;
      load_q      <= mem_load_data_i;
      pc4_q       <= mem_pc4_i;
    end
  end
  // misaligned offsets truncate to the access size's natural alignment
  assign b = 8'(load_q >> {addr_q, 3'b000});
  assign h = 16'(load_q >> {addr_q[2:1], 4'b0000});
  assign w = 32'(load_q >> {addr_q[2], 5'b00000});
  always_comb begin
    load_ext = funct3_q[1:0] == 2'b00 ? {{(XLEN-8){b[7] & ~funct3_q[2]}}, b}
             : funct3_q[1:0] == 2'b01 ? {{(XLEN-16){h[15] & ~funct3_q[2]}}, h}
             : funct3_q[1:0] == 2'b10 ? {{(XLEN-32){w[31] & ~funct3_q[2]}}, w}
             : load_q;
  end
  assign write_data = sel_q == 2'b01 ? load_ext : sel_q == 2'b10 ? pc4_q : alu_q;
  assign RegWrite   = valid_q & reg_write_q & (rd_q != '0);
  assign write_reg  = rd_q;
  assign wb_valid_o = valid_q;
`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;
  always_ff @(posedge clk) begin
    if (!nrst) instret_q <= '0;
    else if (valid_q && !stall_i) instret_q <= instret_q + 64'd1;
  end
  assign instret_o = instret_q;
`endif
endmodule
